led_frame_buffer: RTL

Double-buffered 8x8 red/green frame store that sits directly upstream of the LED matrix row-scan driver and feeds its red and green array inputs. Game/pattern logic writes rows into a hidden back bank through a valid/ready port, then requests a commit. The banks swap only on a frame boundary, so the scan never shows a half-written frame. After each swap, the new back bank is refreshed from the displayed frame, so writers can apply incremental edits.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_bank.sv | 43 ++++
 rtl/led_frame_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame buffer.
//   ROWS_DEF / COLS_DEF : default matrix geometry (8x8).
//   row_t / frame_t     : one colour row and a full colour frame.
//   fb_state_t          : commit/swap/copy controller states.
package led_pkg;

  localparam int unsigned ROWS_DEF = 8;
  localparam int unsigned COLS_DEF = 8;

  typedef logic [COLS_DEF-1:0] row_t;
  typedef row_t [ROWS_DEF-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } fb_state_t;

  // Out-of-range row writes are accepted but discarded; this gates the store.
  function automatic logic row_in_range(input int unsigned row, input int unsigned rows);
    return row < rows;
  endfunction

endpackage

// File: rtl/led_bank.sv
// One red+green frame store for the LED matrix.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (zeroes the bank)
//   clear             : synchronous clear of the whole bank
//   we, row           : single-row write strobe and row index
//   red, green        : row data written when we is high
//   red_frame,
//   green_frame       : full stored frame, row r at [r]
module led_bank
  import led_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF,
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       we,
  input  logic [RowW-1:0]            row,
  input  logic [COLS-1:0]            red,
  input  logic [COLS-1:0]            green,
  output logic [ROWS-1:0][COLS-1:0]  red_frame,
  output logic [ROWS-1:0][COLS-1:0]  green_frame
);

  logic [ROWS-1:0][COLS-1:0] red_q;
  logic [ROWS-1:0][COLS-1:0] green_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      red_q   <= '0;
      green_q <= '0;
    end else if (we && row_in_range(32'(row), ROWS)) begin
      red_q[row]   <= red;
      green_q[row] <= green;
    end
  end

  assign red_frame   = red_q;
  assign green_frame = green_q;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered red/green frame store feeding the LED row-scan driver.
// Writers fill the hidden back bank, then commit; banks swap on the next
// frame_tick, after which the new back bank is refreshed from the new front
// bank one row per cycle so later edits can be incremental.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   wr_valid/wr_ready           : row write handshake into the back bank
//   wr_row, wr_red, wr_green    : row index and pixel data
//   clear                       : zero the back bank (IDLE only)
//   commit                      : request a swap at the next frame boundary
//   commit_busy                 : commit pending or post-swap copy running
//   frame_tick                  : frame boundary pulse from the scan driver
//   red_array, green_array      : displayed frame (front bank, unregistered)
//   swap_count                  : completed swaps, wrapping at 8 bits
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF,
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [RowW-1:0]            wr_row,
  input  logic [COLS-1:0]            wr_red,
  input  logic [COLS-1:0]            wr_green,
  input  logic                       clear,
  input  logic                       commit,
  output logic                       commit_busy,
  input  logic                       frame_tick,
  output logic [ROWS-1:0][COLS-1:0]  red_array,
  output logic [ROWS-1:0][COLS-1:0]  green_array,
  output logic [7:0]                 swap_count
);

  fb_state_t       state_q, state_d;
  logic            front_sel_q, front_sel_d;
  logic [RowW-1:0] copy_idx_q, copy_idx_d;
  logic [7:0]      swap_count_q, swap_count_d;

  // Back-bank port, shared between the writer (IDLE) and the copy engine (COPY).
  logic            back_we;
  logic            back_clear;
  logic [RowW-1:0] back_row;
  logic [COLS-1:0] back_red;
  logic [COLS-1:0] back_green;

  logic [ROWS-1:0][COLS-1:0] red_a, green_a, red_b, green_b;
  logic [ROWS-1:0][COLS-1:0] front_red, front_green;

  // front_sel=0 displays bank A, so bank A only takes writes when front_sel=1.
  led_bank #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_bank_a (
    .clk         (clk),
    .reset       (reset),
    .clear       (back_clear && front_sel_q),
    .we          (back_we && front_sel_q),
    .row         (back_row),
    .red         (back_red),
    .green       (back_green),
    .red_frame   (red_a),
    .green_frame (green_a)
  );

  led_bank #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_bank_b (
    .clk         (clk),
    .reset       (reset),
    .clear       (back_clear && !front_sel_q),
    .we          (back_we && !front_sel_q),
    .row         (back_row),
    .red         (back_red),
    .green       (back_green),
    .red_frame   (red_b),
    .green_frame (green_b)
  );

  assign front_red   = front_sel_q ? red_b : red_a;
  assign front_green = front_sel_q ? green_b : green_a;

  assign red_array   = front_red;
  assign green_array = front_green;
  assign swap_count  = swap_count_q;
  assign commit_busy = (state_q != IDLE);
  assign wr_ready    = (state_q == IDLE) && !clear;

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    copy_idx_d   = copy_idx_q;
    swap_count_d = swap_count_q;
    back_we      = 1'b0;
    back_clear   = 1'b0;
    back_row     = wr_row;
    back_red     = wr_red;
    back_green   = wr_green;

    unique case (state_q)
      IDLE: begin
        back_clear = clear;
        back_we    = wr_valid && wr_ready;
        if (commit) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_tick) begin
          front_sel_d  = !front_sel_q;
          swap_count_d = swap_count_q + 8'd1;
          copy_idx_d   = '0;
          state_d      = COPY;
        end
      end
      COPY: begin
        // front_sel_q already points at the new front bank here.
        back_we    = 1'b1;
        back_row   = copy_idx_q;
        back_red   = front_red[copy_idx_q];
        back_green = front_green[copy_idx_q];
        if (copy_idx_q == RowW'(ROWS - 1)) begin
          state_d = IDLE;
        end else begin
          copy_idx_d = copy_idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      front_sel_q  <= 1'b0;
      copy_idx_q   <= '0;
      swap_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      copy_idx_q   <= copy_idx_d;
      swap_count_q <= swap_count_d;
    end
  end

endmodule
